board_manager: RTL and testbench

BOARD_MANAGER -- requirements
Module: board_manager

---
 rtl/tetris_pkg.sv | 26 ++
 rtl/row_full_detect.sv | 24 ++
 rtl/board_manager.sv | 166 ++++++++++++++++
 tb/tb_board_manager.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared definitions for the playfield blocks (board manager, renderer,
// color mapper).
//   ROWS, COLS   : playfield geometry, row 0 at the top
//   bm_state_t   : board manager FSM state encoding
//   sat_add16    : 16-bit saturating add used for the cleared-line total
package tetris_pkg;

    localparam int ROWS = 20;
    localparam int COLS = 10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MERGE = 3'd1,
        S_SCAN  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } bm_state_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                              input logic [2:0]  b);
        logic [16:0] sum;
        sum = {1'b0, a} + {14'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/row_full_detect.sv
// Combinational full-row detector.
//   board : flattened playfield, bit index = row*COLS + col
//   ptr   : row to test
//   full  : 1 when every column of row ptr is occupied
module row_full_detect
    import tetris_pkg::*;
#(
    parameter int ROWS  = tetris_pkg::ROWS,
    parameter int COLS  = tetris_pkg::COLS,
    parameter int PTR_W = $clog2(ROWS)
) (
    input  logic [ROWS*COLS-1:0] board,
    input  logic [PTR_W-1:0]     ptr,
    output logic                 full
);

    logic [COLS-1:0] row_bits;

    always_comb begin
        row_bits = board[int'(ptr)*COLS +: COLS];
        full     = &row_bits;
    end

endmodule

// File: rtl/board_manager.sv
// Settled-board keeper: merges a locked piece into the playfield, removes
// full rows one at a time from the bottom up, and keeps line statistics.
//   clk, rst_n     : clock, asynchronous active-low reset
//   lock_req       : one-cycle request to merge piece_layer (ignored when busy)
//   piece_layer    : active piece cells, bit index = row*COLS + col
//   clear_board    : new-game request, overrides everything
//   game_state     : settled board, same bit mapping
//   busy           : FSM not idle
//   done           : one-cycle pulse at the end of a lock
//   lines_cleared  : rows removed by the last lock, held until next done
//   lines_total    : saturating cumulative row count
//   top_out        : sticky overlap flag
module board_manager
    import tetris_pkg::*;
#(
    parameter int ROWS = tetris_pkg::ROWS,
    parameter int COLS = tetris_pkg::COLS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lock_req,
    input  logic [ROWS*COLS-1:0] piece_layer,
    input  logic                 clear_board,
    output logic [ROWS*COLS-1:0] game_state,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           lines_cleared,
    output logic [15:0]          lines_total,
    output logic                 top_out
);

    localparam int N     = ROWS * COLS;
    localparam int PTR_W = $clog2(ROWS);

    bm_state_t        state_q, state_d;
    logic [N-1:0]     board_q, board_d;
    logic [N-1:0]     latch_q, latch_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [2:0]       lines_cleared_q, lines_cleared_d;
    logic [15:0]      lines_total_q, lines_total_d;
    logic             top_out_q, top_out_d;

    logic             row_full;
    logic [N-1:0]     shifted;

    row_full_detect #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .PTR_W (PTR_W)
    ) u_row_full (
        .board (board_q),
        .ptr   (ptr_q),
        .full  (row_full)
    );

    // Rows 1..ptr move down by one, row 0 empties, rows below ptr stay.
    always_comb begin
        shifted = board_q;
        for (int r = 0; r < ROWS; r++) begin
            if (r <= int'(ptr_q)) begin
                if (r == 0) begin
                    shifted[0 +: COLS] = '0;
                end else begin
                    shifted[r*COLS +: COLS] = board_q[(r-1)*COLS +: COLS];
                end
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        board_d         = board_q;
        latch_d         = latch_q;
        ptr_d           = ptr_q;
        cnt_d           = cnt_q;
        lines_cleared_d = lines_cleared_q;
        lines_total_d   = lines_total_q;
        top_out_d       = top_out_q;

        if (clear_board) begin
            state_d         = S_IDLE;
            board_d         = '0;
            latch_d         = '0;
            ptr_d           = '0;
            cnt_d           = '0;
            lines_cleared_d = '0;
            lines_total_d   = '0;
            top_out_d       = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (lock_req) begin
                        latch_d = piece_layer;
                        state_d = S_MERGE;
                    end
                end
                S_MERGE: begin
                    board_d = board_q | latch_q;
                    // Overlap means the stack reached the spawn area; the
                    // merge still completes so the renderer shows it.
                    if (|(board_q & latch_q)) begin
                        top_out_d = 1'b1;
                    end
                    ptr_d   = PTR_W'(ROWS - 1);
                    cnt_d   = '0;
                    state_d = S_SCAN;
                end
                S_SCAN: begin
                    if (row_full) begin
                        state_d = S_SHIFT;
                    end else if (ptr_q == '0) begin
                        // Loaded here so the count is visible while done=1.
                        lines_cleared_d = cnt_q;
                        state_d         = S_DONE;
                    end else begin
                        ptr_d = ptr_q - 1'b1;
                    end
                end
                S_SHIFT: begin
                    // Pointer holds so the row that dropped in is rescanned.
                    board_d = shifted;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_SCAN;
                end
                S_DONE: begin
                    lines_total_d = sat_add16(lines_total_q, cnt_q);
                    state_d       = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            board_q         <= '0;
            latch_q         <= '0;
            ptr_q           <= '0;
            cnt_q           <= '0;
            lines_cleared_q <= '0;
            lines_total_q   <= '0;
            top_out_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            board_q         <= board_d;
            latch_q         <= latch_d;
            ptr_q           <= ptr_d;
            cnt_q           <= cnt_d;
            lines_cleared_q <= lines_cleared_d;
            lines_total_q   <= lines_total_d;
            top_out_q       <= top_out_d;
        end
    end

    assign game_state    = board_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign lines_cleared = lines_cleared_q;
    assign lines_total   = lines_total_q;
    assign top_out       = top_out_q;

endmodule

// File: tb/tb_board_manager.sv
// Directed bench for board_manager: latency, row clearing, overlap flag,
// ignored requests, clear priority, asynchronous reset and saturation.
module tb_board_manager;
    import tetris_pkg::*;

    localparam int N = ROWS * COLS;

    logic         clk;
    logic         rst_n;
    logic         lock_req;
    logic [N-1:0] piece_layer;
    logic         clear_board;
    logic [N-1:0] game_state;
    logic         busy;
    logic         done;
    logic [2:0]   lines_cleared;
    logic [15:0]  lines_total;
    logic         top_out;

    int n_checks = 0;
    int n_err    = 0;

    board_manager #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lock_req      (lock_req),
        .piece_layer   (piece_layer),
        .clear_board   (clear_board),
        .game_state    (game_state),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .lines_total   (lines_total),
        .top_out       (top_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] rowv(input int r, input logic [COLS-1:0] m);
        logic [N-1:0] v;
        v = '0;
        v[r*COLS +: COLS] = m;
        return v;
    endfunction

    logic [63:0] busy_hist;
    logic [2:0]  lc_at_done;

    // Cycle 0 carries lock_req; cycles 1..50 are observed #1 after each edge.
    // rp_a/rp_b re-pulse lock_req with an all-ones piece, clr_at pulses
    // clear_board, rst_at drops rst_n mid-cycle for two cycles (-1 = unused).
    task automatic run_lock(input logic [N-1:0] piece, input int rp_a,
                            input int rp_b, input int clr_at, input int rst_at,
                            output int done_cyc, output int n_done);
        done_cyc  = -1;
        n_done    = 0;
        busy_hist = '0;
        @(posedge clk); #1;
        piece_layer = piece;
        lock_req    = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            lock_req    = (c == rp_a) || (c == rp_b);
            piece_layer = lock_req ? {N{1'b1}} : piece;
            clear_board = (c == clr_at);
            if (c == rst_at + 2) rst_n = 1'b1;
            busy_hist[c] = busy;
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc   = c;
                    lc_at_done = lines_cleared;
                end
            end
            if (c == rst_at) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("rst_async_outputs",
                      {game_state, busy, done, lines_cleared, lines_total, top_out},
                      '0);
            end
        end
        lock_req    = 1'b0;
        clear_board = 1'b0;
    endtask

    task automatic do_clear();
        @(posedge clk); #1;
        clear_board = 1'b1;
        @(posedge clk); #1;
        clear_board = 1'b0;
    endtask

    logic [N-1:0] exp_gs;
    int dc, nd;

    initial begin
        rst_n       = 1'b0;
        lock_req    = 1'b0;
        piece_layer = '0;
        clear_board = 1'b0;
        lc_at_done  = '0;
        #23;
        check("reset_state",
              {game_state, busy, done, lines_cleared, lines_total, top_out}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Empty board, four cells on the bottom row.
        run_lock(rowv(19, 10'h00F), -1, -1, -1, -1, dc, nd);
        check("t1_done_cycle", dc, 22);
        check("t1_done_count", nd, 1);
        check("t1_busy_1_22", busy_hist[22:1], {22{1'b1}});
        check("t1_busy_after", busy_hist[23], 0);
        check("t1_lines", lc_at_done, 0);
        check("t1_board", game_state, rowv(19, 10'h00F));

        // Fill row 19 except col 9, then an I piece in col 9 clears it.
        run_lock(rowv(19, 10'h1F0) | rowv(18, 10'h021), -1, -1, -1, -1, dc, nd);
        check("t2a_done_cycle", dc, 22);
        run_lock(rowv(16, 10'h200) | rowv(17, 10'h200) | rowv(18, 10'h200)
                 | rowv(19, 10'h200), -1, -1, -1, -1, dc, nd);
        check("t2_done_cycle", dc, 24);
        check("t2_lines", lc_at_done, 1);
        exp_gs = rowv(19, 10'h221) | rowv(18, 10'h200) | rowv(17, 10'h200);
        check("t2_board", game_state, exp_gs);
        check("t2_row0", game_state[COLS-1:0], 0);
        check("t2_total", lines_total, 1);
        check("t2_top_out", top_out, 0);

        do_clear();
        check("clr1_all", {game_state, busy, lines_cleared, lines_total, top_out}, '0);

        // Four full rows after the merge.
        run_lock(rowv(16, 10'h1FF) | rowv(17, 10'h1FF) | rowv(18, 10'h1FF)
                 | rowv(19, 10'h1FF) | rowv(12, 10'h001) | rowv(13, 10'h002)
                 | rowv(14, 10'h004) | rowv(15, 10'h008), -1, -1, -1, -1, dc, nd);
        run_lock(rowv(16, 10'h200) | rowv(17, 10'h200) | rowv(18, 10'h200)
                 | rowv(19, 10'h200), -1, -1, -1, -1, dc, nd);
        check("t3_done_cycle", dc, 30);
        check("t3_lines", lc_at_done, 4);
        exp_gs = rowv(16, 10'h001) | rowv(17, 10'h002) | rowv(18, 10'h004)
                 | rowv(19, 10'h008);
        check("t3_board", game_state, exp_gs);
        check("t3_total", lines_total, 4);
        check("t3_lines_held", lines_cleared, 4);

        // Overlap sets the sticky flag; a clean lock leaves it set.
        run_lock(rowv(19, 10'h008), -1, -1, -1, -1, dc, nd);
        check("t4_top_out", top_out, 1);
        check("t4_board", game_state, exp_gs);
        check("t4_done_cycle", dc, 22);
        run_lock(rowv(0, 10'h001), -1, -1, -1, -1, dc, nd);
        check("t4_top_sticky", top_out, 1);
        check("t4_board2", game_state, exp_gs | rowv(0, 10'h001));
        check("t4_lines_zero", lines_cleared, 0);
        do_clear();
        check("t4_clr_top", top_out, 0);
        check("t4_clr_board", game_state, 0);
        check("t4_clr_stats", {lines_total, lines_cleared, busy}, 0);

        // Re-pulses while busy are ignored.
        run_lock(rowv(0, 10'h001), 5, 22, -1, -1, dc, nd);
        check("t5_done_count", nd, 1);
        check("t5_done_cycle", dc, 22);
        check("t5_board", game_state, rowv(0, 10'h001));

        // clear_board mid-operation.
        run_lock(rowv(1, 10'h001), -1, -1, 10, -1, dc, nd);
        check("t6_busy_c10", busy_hist[10], 1);
        check("t6_idle_c11", busy_hist[11], 0);
        check("t6_no_done", nd, 0);
        check("t6_board", game_state, 0);

        // Reset during a clearing operation.
        run_lock(rowv(16, 10'h1FF) | rowv(17, 10'h1FF) | rowv(18, 10'h1FF)
                 | rowv(19, 10'h1FF), -1, -1, -1, -1, dc, nd);
        run_lock(rowv(16, 10'h200) | rowv(17, 10'h200) | rowv(18, 10'h200)
                 | rowv(19, 10'h200), -1, -1, -1, 12, dc, nd);
        check("t7_no_done", nd, 0);
        check("t7_after_rst",
              {game_state, busy, lines_cleared, lines_total, top_out}, '0);

        // Saturation of the running total.
        force dut.lines_total_q = 16'd65534;
        #1;
        release dut.lines_total_q;
        #1;
        check("t8_preload", lines_total, 65534);
        run_lock(rowv(16, 10'h1FF) | rowv(17, 10'h1FF) | rowv(18, 10'h1FF)
                 | rowv(19, 10'h1FF), -1, -1, -1, -1, dc, nd);
        run_lock(rowv(16, 10'h200) | rowv(17, 10'h200) | rowv(18, 10'h200)
                 | rowv(19, 10'h200), -1, -1, -1, -1, dc, nd);
        check("t8_done_cycle", dc, 30);
        check("t8_lines", lc_at_done, 4);
        check("t8_total_sat", lines_total, 65535);
        check("t8_board", game_state, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
